binary_to_7led_dec: RTL and testbench

Drives a 4-digit multiplexed seven-segment display from a 16-bit value. Each 4-bit nibble of the input is shown as one hex digit. The block scans the four digits in turn, one at a time, and decodes the active nibble into an active-low segment pattern. It sits between the game/score logic and the board's display pins.

---
 rtl/binary_to_7led_dec_pkg.sv | 27 ++
 rtl/seg7_hex_decode.sv | 11 +
 rtl/binary_to_7led_dec.sv | 55 +++++
 tb/tb_binary_to_7led_dec.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/binary_to_7led_dec_pkg.sv
// rtl/binary_to_7led_dec_pkg.sv - shared seven-segment display constants
package binary_to_7led_dec_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Active-low patterns in g..a order, entry n is the glyph for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to active-low segment decoder
module seg7_hex_decode
  import binary_to_7led_dec_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/binary_to_7led_dec.sv
// rtl/binary_to_7led_dec.sv - 4-digit multiplexed seven-segment scanner
module binary_to_7led_dec
  import binary_to_7led_dec_pkg::*;
#(
  parameter int REFRESH_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] big_bin,
  output logic [7:0]  sevenPlus,
  output logic [3:0]  AN
);

  logic [REFRESH_W-1:0] prescaler_q, prescaler_d;
  logic [1:0]           idx_q, idx_d;
  logic [3:0]           nib;
  logic [6:0]           seg;
  logic [7:0]           seven_q;
  logic [3:0]           an_q;

  // The prescaler is only an enable for the scan index; no derived clocks.
  always_comb begin
    prescaler_d = prescaler_q + 1'b1;
    idx_d       = idx_q;
    if (&prescaler_q) begin
      idx_d = idx_q + 2'd1;
    end
  end

  assign nib = big_bin[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_decode (
    .nib_i (nib),
    .seg_o (seg)
  );

  // Anode and pattern share one register stage so they always switch together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler_q <= '0;
      idx_q       <= 2'd0;
      seven_q     <= {1'b1, SEG_BLANK};
      an_q        <= AN_OFF;
    end else begin
      prescaler_q <= prescaler_d;
      idx_q       <= idx_d;
      seven_q     <= {1'b1, seg};
      an_q        <= ~(4'b0001 << idx_q);
    end
  end

  assign sevenPlus = seven_q;
  assign AN        = an_q;

endmodule

// File: tb/tb_binary_to_7led_dec.sv
// tb/tb_binary_to_7led_dec.sv - self-checking bench for binary_to_7led_dec
module tb_binary_to_7led_dec;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst16_n;
  logic [15:0] big_bin;
  logic [7:0]  seven;
  logic [3:0]  an;
  logic [7:0]  seven16;
  logic [3:0]  an16;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [3:0] exp_an;
  logic [7:0] exp_seg;
  logic [6:0] tbl [16];

  always #5 clk = ~clk;

  binary_to_7led_dec #(.REFRESH_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .big_bin   (big_bin),
    .sevenPlus (seven),
    .AN        (an)
  );

  binary_to_7led_dec dut16 (
    .clk       (clk),
    .rst_n     (rst16_n),
    .big_bin   (big_bin),
    .sevenPlus (seven16),
    .AN        (an16)
  );

  // Model: after the n-th edge out of reset, digit floor(n / 2^W) mod 4 is shown.
  task automatic tick();
    int digit;
    @(posedge clk);
    if (!rst_n) begin
      cyc     = -1;
      exp_an  = 4'hF;
      exp_seg = 8'hFF;
    end else begin
      cyc     = cyc + 1;
      digit   = (cyc / (1 << W)) % 4;
      exp_an  = 4'hF ^ (4'(1) << digit);
      exp_seg = {1'b1, tbl[(big_bin >> (4 * digit)) & 16'hF]};
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    checks++;
    assert (an === exp_an) else begin
      errors++;
      $error("FAIL %s AN observed %b expected %b (cyc %0d)", tag, an, exp_an, cyc);
    end
    checks++;
    assert (seven === exp_seg) else begin
      errors++;
      $error("FAIL %s sevenPlus observed %b expected %b (cyc %0d)", tag, seven, exp_seg, cyc);
    end
  endtask

  task automatic check_lit(input string tag, input logic [3:0] want_an, input logic [7:0] want_seg);
    checks++;
    assert (an === want_an) else begin
      errors++;
      $error("FAIL %s AN observed %b expected %b", tag, an, want_an);
    end
    checks++;
    assert (seven === want_seg) else begin
      errors++;
      $error("FAIL %s sevenPlus observed %b expected %b", tag, seven, want_seg);
    end
  endtask

  task automatic wait_an(input logic [3:0] target, input string tag);
    int n;
    n = 0;
    while (an !== target && n < 40) begin
      tick();
      check_model(tag);
      n++;
    end
    checks++;
    assert (an === target) else begin
      errors++;
      $error("FAIL %s wait AN observed %b expected %b", tag, an, target);
    end
  endtask

  initial begin
    int dwell;
    logic [3:0] first_an;
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    cyc     = -1;
    rst_n   = 1'b0;
    rst16_n = 1'b0;
    big_bin = 16'h1234;

    for (int i = 0; i < 3; i++) begin
      tick();
      check_lit("reset", 4'hF, 8'hFF);
    end
    rst_n = 1'b1;
    tick();
    check_lit("first_edge", 4'b1110, 8'b1_0011001);

    for (int i = 0; i < 19; i++) begin
      tick();
      check_model("full_scan");
    end
    check_lit("scan_wrap", 4'b1110, 8'b1_0011001);

    for (int n = 0; n < 16; n++) begin
      big_bin = {4{4'(n)}};
      tick();
      check_model("decode_sweep");
      checks++;
      assert (seven === {1'b1, tbl[n]}) else begin
        errors++;
        $error("FAIL decode_%0d observed %b expected %b", n, seven, {1'b1, tbl[n]});
      end
    end

    big_bin = 16'h0000;
    wait_an(4'b1011, "live_wait");
    big_bin = 16'h0800;
    tick();
    check_lit("live_update", 4'b1011, 8'b1_0000000);
    for (int i = 0; i < 14; i++) begin
      tick();
      check_model("live_others");
    end

    for (int i = 0; i < 200; i++) begin
      big_bin = 16'($urandom);
      tick();
      check_model("random");
    end

    wait_an(4'b0111, "midreset_wait");
    rst_n = 1'b0;
    tick();
    check_lit("mid_reset", 4'hF, 8'hFF);
    rst_n   = 1'b1;
    big_bin = 16'hABCD;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_lit("restart_dwell", 4'b1110, {1'b1, tbl[13]});
    end
    tick();
    check_lit("restart_next", 4'b1101, {1'b1, tbl[12]});

    tick();
    rst16_n = 1'b1;
    tick();
    first_an = an16;
    checks++;
    assert (first_an === 4'b1110) else begin
      errors++;
      $error("FAIL dwell16_start AN observed %b expected %b", first_an, 4'b1110);
    end
    dwell = 0;
    while (an16 === first_an && dwell < 70000) begin
      tick();
      dwell++;
    end
    checks++;
    assert (dwell == 65536) else begin
      errors++;
      $error("FAIL dwell16 cycles observed %0d expected %0d", dwell, 65536);
    end
    checks++;
    assert (an16 === 4'b1101) else begin
      errors++;
      $error("FAIL dwell16_next AN observed %b expected %b", an16, 4'b1101);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
